pipe_hazard_unit: RTL and testbench
===================================

Name: pipe_hazard_unit

Overview:
- Parametrised hazard-detection and forwarding controller for the in-order pipeline: PC -> IF_ID -> decode -> DEC_ALU -> ALU_MEM -> MEM_WB.
- Keeps an internal scoreboard of in-flight destination registers, one entry per post-decode stage.
- Produces per-operand forwarding selects, load-use stalls and multi-cycle redirect flushes.
- Sits beside the decoder; its outputs drive PC/IF_ID enables, the pipeline-register bubble inserts and the ALU operand muxes.

Parameters:
- REG_ADDR_W, 5, register address width.
- STAGES, 3, number of post-decode stages tracked (1 = EX/DEC_ALU out, 2 = ALU_MEM out, 3 = MEM_WB out).
- LOAD_READY, 3, first stage index at which load data is forwardable; 1 <= LOAD_READY <= STAGES.
- FLUSH_CYCLES, 2, cycles flushOut stays high after a redirect; >= 1.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock.
- resetIn  in  1  synchronous active-high reset.
- decValid  in  1  decode stage holds a real instruction.
- decRs1  in  REG_ADDR_W  source register 1.
- decRs2  in  REG_ADDR_W  source register 2.
- decRs1Used  in  1  rs1 is read by this instruction.
- decRs2Used  in  1  rs2 is read by this instruction.
- decRd  in  REG_ADDR_W  destination register.
- decWriteEnable  in  1  instruction writes rd.
- decIsLoad  in  1  instruction is a load.
- redirect  in  1  taken branch/jump resolved this cycle.
- stall  out  1  hold PC and IF_ID; insert a bubble into stage 1.
- flushOut  out  1  squash IF_ID and decode contents.
- fwdSel1  out  $clog2(STAGES+1)  operand 1 source: 0 = register file, k = stage k.
- fwdSel2  out  $clog2(STAGES+1)  operand 2 source, same encoding.
- stallCount  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Scoreboard:
  - STAGES entries, each {valid, rd, isLoad}.
  - Each cycle entry k moves to k+1; entry STAGES retires (its writeback lands in the register file at that clock edge).
  - Entry 1 loads from decode when decValid & decWriteEnable & decRd != 0 & !stall & !flushOut.
  - Otherwise entry 1 becomes invalid (bubble).
  - The scoreboard never freezes; stalls only hold the front end.
- Match rule: stage k matches operand n when entry[k].valid, entry[k].rd == decRsn, decRsnUsed and decRsn != 0. Register x0 never produces a hazard or a forward.
- Forwarding (combinational from scoreboard and decode inputs):
  - fwdSeln = the lowest k that matches (youngest producer wins); 0 if none.
  - A matching load entry with k < LOAD_READY still wins priority but raises stall; fwdSeln is then don't-care and is driven 0.
- Load-use stall (combinational):
  - stall = decValid & !flushOut & (operand 1 or operand 2 has a youngest match that is a load with k < LOAD_READY).
  - Because bubbles advance, stall lasts LOAD_READY - k cycles. With defaults, a load immediately followed by its use stalls 2 cycles, then fwdSel = 3.
- Redirect / flush:
  - redirect sets a down-counter to FLUSH_CYCLES.
  - flushOut = (counter != 0) | redirect; the counter decrements each cycle while nonzero.
  - redirect while the counter is nonzero reloads it to FLUSH_CYCLES.
  - redirect has priority over stall: stall is forced 0 whenever flushOut is 1.
  - Entries already in stages >= 1 are not squashed; they are older than the branch.
- stallCount increments on each cycle with stall = 1 and saturates at all-ones.
- Reset (synchronous, resetIn sampled at posedge clk):
  - All entries invalid, flush counter 0, stallCount 0.
  - Consequently stall = 0, flushOut = 0 (unless redirect is asserted) and fwdSel1/2 = 0.
  - Reset asserted mid-stall or mid-flush clears both on the next edge.
- Latency: forwarding and stall are 0-cycle combinational; the scoreboard and flush counter update on the clock edge.

Decomposition:
- Shared package/define file holds:
  - forwarding select encodings (FWD_REG = 0, FWD_STAGE base);
  - scoreboard entry struct {valid, rd, isLoad};
  - default widths, using the existing RegAddrSize define.
- One sub-module, hazard_match: combinational per-operand priority matcher, instantiated twice (rs1, rs2); takes the flattened scoreboard and returns {fwdSel, loadHazard}.

Test Plan:
- Back-to-back ALU dependency: add x5 -> next cycle use x5 as rs1 -> fwdSel1 = 1, stall = 0. One bubble between them -> fwdSel1 = 2. Two bubbles -> fwdSel1 = 3.
- Load-use: load x7, then add using x7 as rs2 -> stall = 1 for 2 cycles, stallCount = 2, then fwdSel2 = 3 and stall = 0.
- x0 and unused operands: writes to x0 followed by a read of x0 -> fwdSel = 0. rs2 matches but decRs2Used = 0 -> fwdSel2 = 0, no stall.
- Youngest wins: x3 written in stages 1 and 2 -> fwdSel1 = 1. Same, but the stage-1 producer is a load -> stall = 1.
- Redirect: pulse for 1 cycle -> flushOut high 3 cycles (pulse + FLUSH_CYCLES = 2). Second redirect during flush -> extends. Redirect during load-use stall -> stall = 0 and the decode write is not entered.
- Reset mid-operation: resetIn during a stall with a full scoreboard -> next cycle stall = 0, fwdSel = 0, stallCount = 0. stallCount saturation checked with CNT_W = 2 -> holds at 3.

Source files
------------

// File: rtl/pipe_hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit_pkg
//   Shared definitions for the pipeline hazard / forwarding controller:
//   default widths, forwarding-select encodings and the scoreboard entry
//   layout. No ports; imported by pipe_hazard_unit and hazard_match.
// ---------------------------------------------------------------------------
`ifndef RegAddrSize
`define RegAddrSize 5
`endif

package pipe_hazard_unit_pkg;

  // Default configuration of the in-order pipeline.
  localparam int DefRegAddrW   = `RegAddrSize;
  localparam int DefStages     = 3;
  localparam int DefLoadReady  = 3;
  localparam int DefFlushCycles = 2;
  localparam int DefCntW       = 16;

  // Forwarding select encodings: FWD_REG reads the register file, stage k
  // (1-based, 1 = youngest post-decode stage) is encoded as FWD_STAGE + k - 1.
  localparam int FWD_REG   = 0;
  localparam int FWD_STAGE = 1;

  // One scoreboard entry as held for each post-decode stage (default widths).
  typedef struct packed {
    logic                    valid;
    logic [`RegAddrSize-1:0] rd;
    logic                    isLoad;
  } sbEntry_t;

endpackage

// File: rtl/pipe_hazard_unit_hazard_match.sv
// ---------------------------------------------------------------------------
// hazard_match
//   Combinational priority matcher for one source operand against the
//   flattened scoreboard. The youngest matching producer wins; if that
//   producer is a load whose data is not yet available, loadHazard is raised
//   and the select is driven to the register-file encoding.
//
//   sbValid    in  STAGES              per-stage entry valid (bit 0 = stage 1)
//   sbRd       in  STAGES*REG_ADDR_W   per-stage destination registers
//   sbIsLoad   in  STAGES              per-stage load flag
//   rs         in  REG_ADDR_W          source register of the operand
//   rsUsed     in  1                   operand is actually read
//   fwdSel     out SEL_W               0 = register file, k = stage k
//   loadHazard out 1                   youngest producer is an unready load
// ---------------------------------------------------------------------------
module hazard_match
  import pipe_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = DefRegAddrW,
  parameter int STAGES     = DefStages,
  parameter int LOAD_READY = DefLoadReady,
  parameter int SEL_W      = $clog2(STAGES + 1)
) (
  input  logic [STAGES-1:0]            sbValid,
  input  logic [STAGES*REG_ADDR_W-1:0] sbRd,
  input  logic [STAGES-1:0]            sbIsLoad,
  input  logic [REG_ADDR_W-1:0]        rs,
  input  logic                         rsUsed,
  output logic [SEL_W-1:0]             fwdSel,
  output logic                         loadHazard
);

  logic [STAGES-1:0] hit;
  logic              found;

  // x0 is hard-wired zero, so it never matches anything.
  always_comb begin
    hit = '0;
    for (int k = 0; k < STAGES; k++) begin
      hit[k] = sbValid[k] && rsUsed && (rs != '0) &&
               (sbRd[k*REG_ADDR_W +: REG_ADDR_W] == rs);
    end
  end

  // Scan from the youngest stage; the first hit decides. A load that is too
  // young still claims priority so an older, stale producer cannot forward.
  always_comb begin
    fwdSel     = SEL_W'(FWD_REG);
    loadHazard = 1'b0;
    found      = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (hit[k] && !found) begin
        found = 1'b1;
        if (sbIsLoad[k] && ((k + 1) < LOAD_READY)) begin
          loadHazard = 1'b1;
        end else begin
          fwdSel = SEL_W'(FWD_STAGE + k);
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit
//   Hazard detection and forwarding controller for the in-order pipeline
//   PC -> IF_ID -> decode -> DEC_ALU -> ALU_MEM -> MEM_WB. Tracks in-flight
//   destination registers per post-decode stage, produces operand forwarding
//   selects, load-use stalls, a multi-cycle flush after a redirect and a
//   saturating stall counter.
//
//   clk            in  1           clock
//   resetIn        in  1           synchronous active-high reset
//   decValid       in  1           decode holds a real instruction
//   decRs1/decRs2  in  REG_ADDR_W  source registers
//   decRs1Used/2   in  1           source register is read
//   decRd          in  REG_ADDR_W  destination register
//   decWriteEnable in  1           instruction writes rd
//   decIsLoad      in  1           instruction is a load
//   redirect       in  1           taken branch/jump resolved this cycle
//   stall          out 1           hold PC/IF_ID, bubble into stage 1
//   flushOut       out 1           squash IF_ID and decode
//   fwdSel1/2      out SEL_W       0 = register file, k = stage k
//   stallCount     out CNT_W       saturating stall-cycle count
// ---------------------------------------------------------------------------
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W   = DefRegAddrW,
  parameter int STAGES       = DefStages,
  parameter int LOAD_READY   = DefLoadReady,
  parameter int FLUSH_CYCLES = DefFlushCycles,
  parameter int CNT_W        = DefCntW,
  localparam int SEL_W       = $clog2(STAGES + 1),
  localparam int FCNT_W      = $clog2(FLUSH_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  resetIn,
  input  logic                  decValid,
  input  logic [REG_ADDR_W-1:0] decRs1,
  input  logic [REG_ADDR_W-1:0] decRs2,
  input  logic                  decRs1Used,
  input  logic                  decRs2Used,
  input  logic [REG_ADDR_W-1:0] decRd,
  input  logic                  decWriteEnable,
  input  logic                  decIsLoad,
  input  logic                  redirect,
  output logic                  stall,
  output logic                  flushOut,
  output logic [SEL_W-1:0]      fwdSel1,
  output logic [SEL_W-1:0]      fwdSel2,
  output logic [CNT_W-1:0]      stallCount
);

  if (LOAD_READY < 1 || LOAD_READY > STAGES) begin : gBadLoadReady
    $error("pipe_hazard_unit: LOAD_READY must lie in 1..STAGES");
  end
  if (FLUSH_CYCLES < 1) begin : gBadFlushCycles
    $error("pipe_hazard_unit: FLUSH_CYCLES must be at least 1");
  end

  // Scoreboard, bit/slice k-1 describes stage k.
  logic [STAGES-1:0]            sbValid;
  logic [STAGES*REG_ADDR_W-1:0] sbRd;
  logic [STAGES-1:0]            sbIsLoad;

  logic [FCNT_W-1:0] flushCnt;
  logic              loadHaz1;
  logic              loadHaz2;
  logic              enterP0;

  hazard_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .STAGES     (STAGES),
    .LOAD_READY (LOAD_READY),
    .SEL_W      (SEL_W)
  ) uMatchRs1 (
    .sbValid    (sbValid),
    .sbRd       (sbRd),
    .sbIsLoad   (sbIsLoad),
    .rs         (decRs1),
    .rsUsed     (decRs1Used),
    .fwdSel     (fwdSel1),
    .loadHazard (loadHaz1)
  );

  hazard_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .STAGES     (STAGES),
    .LOAD_READY (LOAD_READY),
    .SEL_W      (SEL_W)
  ) uMatchRs2 (
    .sbValid    (sbValid),
    .sbRd       (sbRd),
    .sbIsLoad   (sbIsLoad),
    .rs         (decRs2),
    .rsUsed     (decRs2Used),
    .fwdSel     (fwdSel2),
    .loadHazard (loadHaz2)
  );

  // A redirect squashes decode in its own cycle, and a squashed or
  // redirected-away instruction must never stall the front end.
  always_comb begin
    flushOut = (flushCnt != '0) | redirect;
    stall    = decValid & ~flushOut & (loadHaz1 | loadHaz2);
    enterP0  = decValid & decWriteEnable & (decRd != '0) & ~stall & ~flushOut;
  end

  // ---- decode -> stage 1 .. stage STAGES boundary ----
  // The scoreboard always advances; a stall or flush simply inserts a bubble
  // into stage 1, which is how a load ages into forwardable range.
  always_ff @(posedge clk) begin
    if (resetIn) begin
      sbValid <= '0;
    end else begin
      sbValid[0] <= enterP0;
      for (int k = 1; k < STAGES; k++) begin
        sbValid[k] <= sbValid[k-1];
      end
    end
  end

  // Entry payload only matters while the matching valid bit is set.
  always_ff @(posedge clk) begin
    sbRd[REG_ADDR_W-1:0] <= decRd;
    sbIsLoad[0]          <= decIsLoad;
    for (int k = 1; k < STAGES; k++) begin
      sbRd[k*REG_ADDR_W +: REG_ADDR_W] <= sbRd[(k-1)*REG_ADDR_W +: REG_ADDR_W];
      sbIsLoad[k]                      <= sbIsLoad[k-1];
    end
  end

  // A redirect during an ongoing flush restarts the full window.
  always_ff @(posedge clk) begin
    if (resetIn) begin
      flushCnt <= '0;
    end else if (redirect) begin
      flushCnt <= FCNT_W'(FLUSH_CYCLES);
    end else if (flushCnt != '0) begin
      flushCnt <= flushCnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetIn) begin
      stallCount <= '0;
    end else if (stall && (stallCount != '1)) begin
      stallCount <= stallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
module tb_pipe_hazard_unit;

  localparam int W  = 5;
  localparam int ST = 3;
  localparam int LR = 3;
  localparam int FC = 2;
  localparam int CW = 16;
  localparam int SW = $clog2(ST + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetIn, decValid, decRs1Used, decRs2Used;
  logic          decWriteEnable, decIsLoad, redirect;
  logic [W-1:0]  decRs1, decRs2, decRd;
  logic          stall, flushOut, stallB, flushOutB;
  logic [SW-1:0] fwdSel1, fwdSel2, fwdSel1B, fwdSel2B;
  logic [CW-1:0] stallCount;
  logic [1:0]    stallCountB;

  pipe_hazard_unit #(
    .REG_ADDR_W(W), .STAGES(ST), .LOAD_READY(LR), .FLUSH_CYCLES(FC), .CNT_W(CW)
  ) dut (
    .clk(clk), .resetIn(resetIn), .decValid(decValid),
    .decRs1(decRs1), .decRs2(decRs2), .decRs1Used(decRs1Used), .decRs2Used(decRs2Used),
    .decRd(decRd), .decWriteEnable(decWriteEnable), .decIsLoad(decIsLoad),
    .redirect(redirect), .stall(stall), .flushOut(flushOut),
    .fwdSel1(fwdSel1), .fwdSel2(fwdSel2), .stallCount(stallCount)
  );

  // Narrow-counter instance for saturation.
  pipe_hazard_unit #(
    .REG_ADDR_W(W), .STAGES(ST), .LOAD_READY(LR), .FLUSH_CYCLES(FC), .CNT_W(2)
  ) dutSat (
    .clk(clk), .resetIn(resetIn), .decValid(decValid),
    .decRs1(decRs1), .decRs2(decRs2), .decRs1Used(decRs1Used), .decRs2Used(decRs2Used),
    .decRd(decRd), .decWriteEnable(decWriteEnable), .decIsLoad(decIsLoad),
    .redirect(redirect), .stall(stallB), .flushOut(flushOutB),
    .fwdSel1(fwdSel1B), .fwdSel2(fwdSel2B), .stallCount(stallCountB)
  );

  typedef struct {
    bit stall;
    bit flush;
    int sel1;
    int sel2;
    int cnt;
    int cntSat;
  } exp_t;

  // Reference model: list of issued register writers with their issue cycle;
  // a writer's stage is simply its age in cycles.
  typedef struct {
    int rd;
    bit isLoad;
    int issue;
  } writer_t;

  exp_t    expQ[$];
  writer_t writers[$];
  int      cycleNo     = 0;
  int      flushRemain = 0;
  int      cnt         = 0;
  int      cntSat      = 0;
  bit      lastStall   = 0;
  int      checks      = 0;
  int      failures    = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  task automatic lookup(input int rs, input bit used, output int sel, output bit haz);
    int best;
    bit bestLoad;
    best = 0;
    bestLoad = 0;
    sel = 0;
    haz = 0;
    if (used && rs != 0) begin
      foreach (writers[i]) begin
        int age;
        age = cycleNo - writers[i].issue;
        if (writers[i].rd == rs && age >= 1 && age <= ST && (best == 0 || age < best)) begin
          best = age;
          bestLoad = writers[i].isLoad;
        end
      end
    end
    if (best != 0) begin
      if (bestLoad && best < LR) haz = 1;
      else sel = best;
    end
  endtask

  task automatic step(input bit rst, input bit v, input int rs1, input bit u1,
                      input int rs2, input bit u2, input int rd, input bit we,
                      input bit ld, input bit rdr);
    exp_t e;
    int   s1, s2;
    bit   h1, h2;
    @(posedge clk);
    #1;
    resetIn = rst; decValid = v; decRs1 = W'(rs1); decRs1Used = u1;
    decRs2 = W'(rs2); decRs2Used = u2; decRd = W'(rd); decWriteEnable = we;
    decIsLoad = ld; redirect = rdr;
    lookup(rs1, u1, s1, h1);
    lookup(rs2, u2, s2, h2);
    e.flush  = rdr || (flushRemain > 0);
    e.stall  = v && !e.flush && (h1 || h2);
    e.sel1   = s1;
    e.sel2   = s2;
    e.cnt    = cnt;
    e.cntSat = cntSat;
    expQ.push_back(e);
    lastStall = e.stall;
    // state as of the coming clock edge
    if (rst) begin
      writers.delete();
      flushRemain = 0;
      cnt = 0;
      cntSat = 0;
    end else begin
      if (e.stall) begin
        if (cnt < (1 << CW) - 1) cnt++;
        if (cntSat < 3) cntSat++;
      end
      if (v && we && rd != 0 && !e.stall && !e.flush)
        writers.push_back('{rd: rd, isLoad: ld, issue: cycleNo});
      flushRemain = rdr ? FC : ((flushRemain > 0) ? flushRemain - 1 : 0);
    end
    cycleNo++;
    while (writers.size() > 0 && (cycleNo - writers[0].issue) > ST) void'(writers.pop_front());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ALU write of rd, no sources.
  task automatic aluW(input int rd);
    step(0, 1, 0, 0, 0, 0, rd, 1, 0, 0);
  endtask

  task automatic loadW(input int rd);
    step(0, 1, 0, 0, 0, 0, rd, 1, 1, 0);
  endtask

  // Monitor: outputs are valid every cycle; compare away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("stall", 32'(stall), 32'(e.stall));
        chk("flushOut", 32'(flushOut), 32'(e.flush));
        chk("fwdSel1", 32'(fwdSel1), 32'(e.sel1));
        chk("fwdSel2", 32'(fwdSel2), 32'(e.sel2));
        chk("stallCount", 32'(stallCount), 32'(e.cnt));
        chk("stallCountSat", 32'(stallCountB), 32'(e.cntSat));
      end
    end
  end

  initial begin
    int rs1, rs2, rd;
    bit v, u1, u2, we, ld, rdr, rst;
    resetIn = 1; decValid = 0; decRs1 = '0; decRs2 = '0; decRs1Used = 0;
    decRs2Used = 0; decRd = '0; decWriteEnable = 0; decIsLoad = 0; redirect = 0;
    repeat (2) @(posedge clk);

    // reset still asserted: outputs clear, redirect still shows as flush
    step(1, 1, 7, 1, 7, 1, 7, 1, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // back-to-back ALU forwarding at distances 1, 2, 3
    aluW(5); step(0, 1, 5, 1, 0, 0, 0, 0, 0, 0); idle(3);
    aluW(5); idle(1); step(0, 1, 5, 1, 0, 0, 0, 0, 0, 0); idle(3);
    aluW(5); idle(2); step(0, 1, 5, 1, 0, 0, 0, 0, 0, 0); idle(3);

    // load-use on rs2: held instruction stalls twice then forwards from stage 3
    loadW(7);
    repeat (3) step(0, 1, 1, 1, 7, 1, 8, 1, 0, 0);
    idle(3);

    // x0 and unused operand
    aluW(0); step(0, 1, 0, 1, 0, 1, 0, 0, 0, 0); idle(3);
    loadW(6); step(0, 1, 0, 0, 6, 0, 0, 0, 0, 0); idle(3);

    // youngest producer wins
    aluW(3); aluW(3); step(0, 1, 3, 1, 0, 0, 0, 0, 0, 0); idle(3);
    aluW(3); loadW(3); step(0, 1, 3, 1, 0, 0, 0, 0, 0, 0); idle(3);

    // redirect pulse, then a second redirect inside the flush window
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); idle(3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); idle(1);
    step(0, 1, 0, 0, 0, 0, 2, 1, 0, 1); idle(4);

    // redirect during load-use stall: no stall, decode write dropped
    loadW(9);
    step(0, 1, 9, 1, 0, 0, 10, 1, 0, 0);
    step(0, 1, 9, 1, 0, 0, 10, 1, 0, 1);
    idle(2);
    step(0, 1, 10, 1, 9, 1, 0, 0, 0, 0); idle(3);

    // reset in the middle of a stall with a full scoreboard
    aluW(11); aluW(12); loadW(4);
    step(0, 1, 4, 1, 11, 1, 0, 0, 0, 0);
    step(1, 1, 4, 1, 11, 1, 0, 0, 0, 0);
    step(0, 1, 4, 1, 11, 1, 0, 0, 0, 0);

    // repeated load-use pairs drive the narrow counter into saturation
    for (int i = 0; i < 3; i++) begin
      loadW(13);
      repeat (3) step(0, 1, 13, 1, 0, 0, 0, 0, 0, 0);
    end
    idle(3);

    // randomized traffic; a stalled instruction is held in decode
    v = 0; rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; we = 0; ld = 0;
    for (int i = 0; i < 800; i++) begin
      if (!lastStall) begin
        v   = ($urandom_range(0, 9) != 0);
        rs1 = $urandom_range(0, 7);
        rs2 = $urandom_range(0, 7);
        rd  = $urandom_range(0, 7);
        u1  = ($urandom_range(0, 3) != 0);
        u2  = ($urandom_range(0, 1) != 0);
        we  = ($urandom_range(0, 4) != 0);
        ld  = ($urandom_range(0, 2) == 0);
      end
      rdr = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 149) == 0);
      step(rst, v, rs1, u1, rs2, u2, rd, we, ld, rdr);
    end

    repeat (2) @(negedge clk);
    chk("queueDrained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
